hub75_bcm_scan_driver: RTL
==========================

// Module: hub75_bcm_scan_driver
// PURPOSE
//  Parametrised RGB LED-matrix scan driver. Fetches pixel pairs (upper/lower half) from a frame buffer, shifts
//  them out on rgb1/rgb2 with generated sclk, latches and drives row_sel/blank. Binary-coded modulation (BCM)
//  per row gives PWM_BITS of intensity per colour. Sits between frame-buffer RAM and panel connector.
// PARAMETERS
//  COLS        32  columns shifted per plane (>=2)
//  ROW_BITS    3   row_sel width; 2**ROW_BITS scanned row pairs
//  PWM_BITS    4   intensity bits per colour channel (>=1)
//  SCLK_DIV    2   clk cycles per sclk half-period (>=1)
//  BASE_TICKS  64  minimum display time of plane 0 in clk cycles; plane b minimum = BASE_TICKS<<b
// PORTS
//  clk       in   1                 system clock; all logic on rising edge
//  reset_n   in   1                 asynchronous reset, active low
//  enable    in   1                 run scan when 1
//  pix_addr  out  ROW_BITS+clog2(COLS)  {row, col} read address to frame buffer
//  pix_data  in   6*PWM_BITS        {r1,g1,b1,r2,g2,b2}, each PWM_BITS; valid exactly 1 clk after pix_addr
//  rgb1      out  3                 {r,g,b} bit for upper half
//  rgb2      out  3                 {r,g,b} bit for lower half
//  sclk      out  1                 panel shift clock; panel samples on rising edge
//  latch     out  1                 1-clk pulse transferring shift register to drivers
//  blank     out  1                 1 = LEDs off
//  row_sel   out  ROW_BITS          displayed row pair
//  frame_done out 1                 1-clk pulse when last plane of last row is latched
// BEHAVIOUR
//  - Reset (async, reset_n=0): sclk=0, latch=0, blank=1, rgb1=rgb2=0, row_sel=0, pix_addr=0, frame_done=0; FSM=IDLE,
//    row=0, plane=0. Reset mid-shift/display aborts immediately; no partial latch.
//  - FSM: IDLE -> SHIFT -> WAIT -> BLANK -> LATCH -> (SHIFT of next plane). Leaves IDLE when enable=1.
//  - SHIFT: for col 0..COLS-1, pix_addr issued 1 clk before sclk low phase starts (pipelined one column ahead);
//    rgb1/rgb2 updated at start of low phase with bit <plane> of each channel; sclk low SCLK_DIV clks, high
//    SCLK_DIV clks. Shift of plane p+1 overlaps display of plane p. sclk ends low.
//  - WAIT: hold until shift complete AND display timer of current plane expired (display = max(shift time,
//    BASE_TICKS<<plane)). First plane after IDLE: no timer, blank stays 1.
//  - BLANK (1 clk): blank=1. LATCH (1 clk): row_sel updated to new row (changes only while blank=1), latch=1.
//    Next clk: latch=0, blank=0, display timer loads BASE_TICKS<<plane and counts down.
//  - Order: row r planes 0..PWM_BITS-1, then row r+1; row 2**ROW_BITS-1 wraps to 0. frame_done pulses in the
//    LATCH cycle of (last row, last plane).
//  - Timer width sized for BASE_TICKS<<(PWM_BITS-1); no overflow allowed.
//  - enable=0: sampled at entry to BLANK; current shift and display complete, then FSM enters BLANK and goes IDLE
//    with blank=1, no latch. Re-enable restarts at row 0, plane 0. enable toggling mid-shift has no effect
//    on that shift.
// CONFIGURATION
//  HUB75_GHOST_BLANK_EN defined: on row change only (plane 0 of new row), 8 extra blank=1 clks inserted
//    between BLANK and LATCH, and row_sel updates at first of those clks; suppresses ghosting.
//  Undefined: blank-high window is exactly 2 clks (BLANK, LATCH) for every plane.
// TESTING (COLS=4, ROW_BITS=1, PWM_BITS=2, SCLK_DIV=1, BASE_TICKS=16 unless noted)
//  1. reset_n=0 mid-shift -> same clk: blank=1, sclk=0, latch=0, row_sel=0, rgb=0; release+enable=1 -> pix_addr 0.
//  2. pix_data r1 = col[0] replicated -> rgb1[2] sampled on sclk rises 0,1,0,1; exactly 4 rises then 1 latch pulse.
//  3. steady state: blank-low windows alternate 16 and 32 clks (plane0, plane1) per row; latch once per plane.
//  4. run 2 frames -> row_sel sequence 0,0,1,1,0,...; frame_done exactly 2 pulses, each in row1/plane1 latch clk.
//  5. enable=0 during shift -> plane finishes, blank=1 held, no latch/sclk for 100 clks; enable=1 -> row 0 plane 0.
//  6. with HUB75_GHOST_BLANK_EN -> blank-high window 10 clks at row change, 2 clks between planes.

Source files
------------

// File: rtl/hub75_bcm_scan_driver.sv
// hub75_bcm_scan_driver
// Scan driver for HUB75-style RGB LED panels using binary-coded modulation.
// Each plane of a row pair is fetched from the frame buffer and shifted out.
// The next plane is shifted while the current one is displayed. Then the panel
// is blanked, the new data is latched, and the next display period starts.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous reset, active low
//   enable      run the scan while high; a stop is taken at the next BLANK
//   pix_addr    {row, col} frame-buffer read address
//   pix_data    {r1,g1,b1,r2,g2,b2}, PWM_BITS each, valid one clk after pix_addr
//   rgb1/rgb2   {r,g,b} serial data for the upper/lower half
//   sclk        panel shift clock (panel samples on the rising edge)
//   latch       one-clk transfer pulse
//   blank       1 = LEDs off
//   row_sel     displayed row pair
//   frame_done  one-clk pulse when the last plane of the last row is latched
//
// Build option
//   HUB75_GHOST_BLANK_EN : when a new row is latched (plane 0), 8 extra blank
//   clks are inserted between BLANK and LATCH, and row_sel changes at the
//   first of them.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | stopped, blank=1, row/plane cleared
// SHIFT    | fetch and shift COLS pixels of the pending plane
// WAIT     | shift done, wait for the current plane's display timer
// BLANK    | one clk with LEDs off before the new data is latched
// GHOST    | extra blank clks at a row change (optional build)
// LATCH    | row_sel/latch update, LEDs still off

module hub75_bcm_scan_driver #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 3,
    parameter int PWM_BITS   = 4,
    parameter int SCLK_DIV   = 2,
    parameter int BASE_TICKS = 64
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  pix_addr,
    input  logic [6*PWM_BITS-1:0]             pix_data,
    output logic [2:0]                        rgb1,
    output logic [2:0]                        rgb2,
    output logic                              sclk,
    output logic                              latch,
    output logic                              blank,
    output logic [ROW_BITS-1:0]               row_sel,
    output logic                              frame_done
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int ADDR_W   = ROW_BITS + COL_BITS;
    localparam int PL_W     = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
    localparam int DIV_W    = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int TMR_MAX  = BASE_TICKS << (PWM_BITS - 1);
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT, ST_WAIT, ST_BLANK, ST_GHOST, ST_LATCH
    } state_t;

    typedef enum logic [1:0] {PH_PRE, PH_LOW, PH_HIGH} phase_t;

    state_t              state_q, state_d;
    phase_t              ph_q, ph_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ROW_BITS-1:0] sh_row_q, sh_row_d;
    logic [PL_W-1:0]     sh_plane_q, sh_plane_d;
    logic                stop_q, stop_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [2:0]          rgb1_q, rgb1_d;
    logic [2:0]          rgb2_q, rgb2_d;
    logic                sclk_q, sclk_d;
    logic                latch_q, latch_d;
    logic                blank_q, blank_d;
    logic [ROW_BITS-1:0] row_sel_q, row_sel_d;
    logic                frame_done_q, frame_done_d;
`ifdef HUB75_GHOST_BLANK_EN
    logic [2:0]          gcnt_q, gcnt_d;
`endif

    logic [PWM_BITS-1:0] ch_r1, ch_g1, ch_b1, ch_r2, ch_g2, ch_b2;
    logic [2:0]          bits1, bits2;
    logic                last_plane, last_row, go_latch;
    logic [PL_W-1:0]     nxt_plane;
    logic [ROW_BITS-1:0] nxt_row;

    assign ch_r1 = pix_data[5*PWM_BITS +: PWM_BITS];
    assign ch_g1 = pix_data[4*PWM_BITS +: PWM_BITS];
    assign ch_b1 = pix_data[3*PWM_BITS +: PWM_BITS];
    assign ch_r2 = pix_data[2*PWM_BITS +: PWM_BITS];
    assign ch_g2 = pix_data[1*PWM_BITS +: PWM_BITS];
    assign ch_b2 = pix_data[0 +: PWM_BITS];

    // sh_row/sh_plane always name the plane being shifted; it becomes the
    // displayed plane at LATCH.
    assign bits1 = {ch_r1[sh_plane_q], ch_g1[sh_plane_q], ch_b1[sh_plane_q]};
    assign bits2 = {ch_r2[sh_plane_q], ch_g2[sh_plane_q], ch_b2[sh_plane_q]};

    assign last_plane = (sh_plane_q == PL_W'(PWM_BITS - 1));
    assign last_row   = &sh_row_q;
    assign nxt_plane  = last_plane ? '0 : sh_plane_q + PL_W'(1);
    assign nxt_row    = last_plane ? sh_row_q + ROW_BITS'(1) : sh_row_q;

    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        col_d        = col_q;
        div_d        = div_q;
        tmr_d        = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
        sh_row_d     = sh_row_q;
        sh_plane_d   = sh_plane_q;
        stop_d       = stop_q;
        pix_addr_d   = pix_addr_q;
        rgb1_d       = rgb1_q;
        rgb2_d       = rgb2_q;
        sclk_d       = sclk_q;
        latch_d      = 1'b0;
        blank_d      = blank_q;
        row_sel_d    = row_sel_q;
        frame_done_d = 1'b0;
        go_latch     = 1'b0;
`ifdef HUB75_GHOST_BLANK_EN
        gcnt_d       = gcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                blank_d    = 1'b1;
                sclk_d     = 1'b0;
                tmr_d      = '0;
                sh_row_d   = '0;
                sh_plane_d = '0;
                stop_d     = 1'b0;
                if (enable) begin
                    state_d    = ST_SHIFT;
                    ph_d       = PH_PRE;
                    div_d      = DIV_W'(1);
                    col_d      = '0;
                    pix_addr_d = '0;
                end
            end

            ST_SHIFT: begin
                case (ph_q)
                    // Two clks for the first read; afterwards the address runs
                    // one column ahead, issued at the start of each low phase.
                    PH_PRE: begin
                        if (div_q == '0) begin
                            ph_d       = PH_LOW;
                            div_d      = DIV_W'(SCLK_DIV - 1);
                            rgb1_d     = bits1;
                            rgb2_d     = bits2;
                            pix_addr_d = {sh_row_q, COL_BITS'(1)};
                        end else begin
                            div_d = div_q - DIV_W'(1);
                        end
                    end
                    PH_LOW: begin
                        if (div_q == '0) begin
                            ph_d   = PH_HIGH;
                            sclk_d = 1'b1;
                            div_d  = DIV_W'(SCLK_DIV - 1);
                        end else begin
                            div_d = div_q - DIV_W'(1);
                        end
                    end
                    PH_HIGH: begin
                        if (div_q == '0) begin
                            sclk_d = 1'b0;
                            if (col_q == COL_BITS'(COLS - 1)) begin
                                state_d = ST_WAIT;
                            end else begin
                                col_d  = col_q + COL_BITS'(1);
                                ph_d   = PH_LOW;
                                div_d  = DIV_W'(SCLK_DIV - 1);
                                rgb1_d = bits1;
                                rgb2_d = bits2;
                                if (col_q < COL_BITS'(COLS - 2))
                                    pix_addr_d = {sh_row_q, col_q + COL_BITS'(2)};
                            end
                        end else begin
                            div_d = div_q - DIV_W'(1);
                        end
                    end
                    default: ph_d = PH_PRE;
                endcase
            end

            // Leaving at tmr==1 makes the blank-low window exactly the loaded count.
            ST_WAIT: begin
                if (tmr_q <= TMR_W'(1)) begin
                    state_d = ST_BLANK;
                    blank_d = 1'b1;
                    stop_d  = ~enable;
                end
            end

            ST_BLANK: begin
                if (stop_q) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef HUB75_GHOST_BLANK_EN
                    if (sh_plane_q == '0) begin
                        state_d   = ST_GHOST;
                        gcnt_d    = 3'd7;
                        row_sel_d = sh_row_q;
                    end else begin
                        go_latch = 1'b1;
                    end
`else
                    go_latch = 1'b1;
`endif
                end
            end

`ifdef HUB75_GHOST_BLANK_EN
            ST_GHOST: begin
                if (gcnt_q == 3'd0)
                    go_latch = 1'b1;
                else
                    gcnt_d = gcnt_q - 3'd1;
            end
`endif

            ST_LATCH: begin
                blank_d    = 1'b0;
                tmr_d      = TMR_W'(BASE_TICKS) << sh_plane_q;
                sh_row_d   = nxt_row;
                sh_plane_d = nxt_plane;
                state_d    = ST_SHIFT;
                ph_d       = PH_PRE;
                div_d      = DIV_W'(1);
                col_d      = '0;
                pix_addr_d = {nxt_row, COL_BITS'(0)};
            end

            default: state_d = ST_IDLE;
        endcase

        if (go_latch) begin
            state_d      = ST_LATCH;
            latch_d      = 1'b1;
            row_sel_d    = sh_row_q;
            frame_done_d = last_row & last_plane;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ph_q         <= PH_PRE;
            col_q        <= '0;
            div_q        <= '0;
            tmr_q        <= '0;
            sh_row_q     <= '0;
            sh_plane_q   <= '0;
            stop_q       <= 1'b0;
            pix_addr_q   <= '0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
            sclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            blank_q      <= 1'b1;
            row_sel_q    <= '0;
            frame_done_q <= 1'b0;
`ifdef HUB75_GHOST_BLANK_EN
            gcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            col_q        <= col_d;
            div_q        <= div_d;
            tmr_q        <= tmr_d;
            sh_row_q     <= sh_row_d;
            sh_plane_q   <= sh_plane_d;
            stop_q       <= stop_d;
            pix_addr_q   <= pix_addr_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
            sclk_q       <= sclk_d;
            latch_q      <= latch_d;
            blank_q      <= blank_d;
            row_sel_q    <= row_sel_d;
            frame_done_q <= frame_done_d;
`ifdef HUB75_GHOST_BLANK_EN
            gcnt_q       <= gcnt_d;
`endif
        end
    end

    assign pix_addr   = pix_addr_q;
    assign rgb1       = rgb1_q;
    assign rgb2       = rgb2_q;
    assign sclk       = sclk_q;
    assign latch      = latch_q;
    assign blank      = blank_q;
    assign row_sel    = row_sel_q;
    assign frame_done = frame_done_q;

endmodule
